// File: rtl/key_conditioner.sv
// Pushbutton conditioner: two-flop synchronizer, per-channel debounce FSM,
// single-cycle press pulses and an async-assert / sync-release reset output.
module key_conditioner #(
  parameter int NUM_BTN         = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_BTN-1:0] Btn_n,
  output logic [NUM_BTN-1:0] Btn_level,
  output logic [NUM_BTN-1:0] Btn_pulse,
  output logic               Reset_sync_h
);

  // Channel state is not stored separately: it is {stable, cnt != 0}.
  typedef enum logic [1:0] {
    ST_RELEASED   = 2'b00,
    ST_PRESS_PEND = 2'b01,
    ST_PRESSED    = 2'b10,
    ST_REL_PEND   = 2'b11
  } btn_state_e;

  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [NUM_BTN-1:0]            s1_q, s2_q;
  logic [NUM_BTN-1:0]            stable_q, stable_d;
  logic [NUM_BTN-1:0]            pulse_q, pulse_d;
  logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                          r1_q, r2_q;
  logic [NUM_BTN-1:0]            pressed_raw;
  btn_state_e                    state [NUM_BTN];

  assign pressed_raw = ~s2_q;

  // State register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_q     <= '1;
      s2_q     <= '1;
      stable_q <= '0;
      cnt_q    <= '0;
      pulse_q  <= '0;
      r1_q     <= 1'b1;
      r2_q     <= 1'b1;
    end else begin
      s1_q     <= Btn_n;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      r1_q     <= 1'b0;
      r2_q     <= r1_q;
    end
  end

  // Next-state logic; the pulse fires on the same edge stable goes high.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    pulse_d  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      state[i] = btn_state_e'({stable_q[i], cnt_q[i] != '0});
      case (state[i])
        ST_RELEASED, ST_PRESSED: begin
          if (pressed_raw[i] != stable_q[i]) cnt_d[i] = CNT_ONE;
        end
        ST_PRESS_PEND, ST_REL_PEND: begin
          if (pressed_raw[i] == stable_q[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_TERM) begin
            stable_d[i] = pressed_raw[i];
            cnt_d[i]    = '0;
            pulse_d[i]  = pressed_raw[i];
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    Btn_level = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      Btn_level[i] = (state[i] == ST_PRESSED) || (state[i] == ST_REL_PEND);
    end
    Btn_pulse    = pulse_q;
    Reset_sync_h = r2_q;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed scenarios with literal checks plus
// random bouncing stimulus compared every cycle against a sliding-window model.
module tb_key_conditioner;

  localparam int NUM_BTN = 3;
  localparam int D       = 4;
  localparam int CNT_W   = 3;
  localparam int W       = 2 * NUM_BTN + 1;

  logic               Clk = 1'b0;
  logic               Reset = 1'b0;
  logic [NUM_BTN-1:0] Btn_n = '1;
  logic [NUM_BTN-1:0] Btn_level;
  logic [NUM_BTN-1:0] Btn_pulse;
  logic               Reset_sync_h;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];

  // Clock / reset block
  initial forever #5 Clk = ~Clk;

  key_conditioner #(
    .NUM_BTN(NUM_BTN),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .Btn_n(Btn_n),
    .Btn_level(Btn_level),
    .Btn_pulse(Btn_pulse),
    .Reset_sync_h(Reset_sync_h)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Reference model: a channel flips when the last D synchronized samples
  // (each Btn_n delayed by two edges) all disagree with the accepted level.
  logic [NUM_BTN-1:0] pipe_m[$];
  logic [NUM_BTN-1:0] raw_hist[$];
  logic [NUM_BTN-1:0] stable_m;
  int                 since_m [NUM_BTN];
  int                 rel_edges;

  always @(posedge Clk) begin
    logic [NUM_BTN-1:0] raw_v;
    logic [NUM_BTN-1:0] pulse_v;
    bit                 all_diff;
    if (!Reset) begin
      pipe_m.delete();
      pipe_m.push_back('1);
      pipe_m.push_back('1);
      raw_hist.delete();
      stable_m  = '0;
      rel_edges = 0;
      for (int i = 0; i < NUM_BTN; i++) since_m[i] = 0;
      exp_q.push_back({1'b1, {NUM_BTN{1'b0}}, {NUM_BTN{1'b0}}});
    end else begin
      raw_v = ~pipe_m.pop_front();
      pipe_m.push_back(Btn_n);
      raw_hist.push_back(raw_v);
      if (raw_hist.size() > D) void'(raw_hist.pop_front());
      pulse_v = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        since_m[i]++;
        all_diff = (since_m[i] >= D);
        if (all_diff) begin
          for (int k = 0; k < D; k++) begin
            if (raw_hist[k][i] == stable_m[i]) all_diff = 1'b0;
          end
        end
        if (all_diff) begin
          stable_m[i] = ~stable_m[i];
          since_m[i]  = 0;
          pulse_v[i]  = stable_m[i];
        end
      end
      if (rel_edges < 1000) rel_edges++;
      exp_q.push_back({(rel_edges < 2), stable_m, pulse_v});
    end
  end

  // Scoreboard: one expectation per rising edge, checked half a cycle later
  always @(negedge Clk) begin
    logic [W-1:0] want;
    if (exp_q.size() != 0) begin
      want = exp_q.pop_front();
      check("cycle", 8'({Reset_sync_h, Btn_level, Btn_pulse}), 8'(want));
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic set_btn(input logic [NUM_BTN-1:0] v);
    @(negedge Clk);
    Btn_n = v;
  endtask

  task automatic assert_reset();
    @(negedge Clk);
    #1 Reset = 1'b0;
    #1;
    check("rst_async_sync_h", 8'(Reset_sync_h), 8'h01);
    check("rst_async_level", 8'(Btn_level), 8'h00);
    check("rst_async_pulse", 8'(Btn_pulse), 8'h00);
  endtask

  task automatic release_reset();
    @(negedge Clk);
    #1 Reset = 1'b1;
  endtask

  int hold [NUM_BTN];

  initial begin
    // 1: reset and release
    tick(3);
    check("rst_sync_h_in_reset", 8'(Reset_sync_h), 8'h01);
    check("rst_level_in_reset", 8'(Btn_level), 8'h00);
    check("rst_pulse_in_reset", 8'(Btn_pulse), 8'h00);
    release_reset();
    tick(1);
    check("rst_sync_h_edge1", 8'(Reset_sync_h), 8'h01);
    tick(1);
    check("rst_sync_h_edge2", 8'(Reset_sync_h), 8'h00);
    tick(2);

    // 2: clean press on channel 0
    set_btn(3'b110);
    tick(5);
    check("press_level_e4", 8'(Btn_level), 8'h00);
    tick(1);
    check("press_level_e5", 8'(Btn_level), 8'h01);
    check("press_pulse_e5", 8'(Btn_pulse), 8'h01);
    tick(1);
    check("press_pulse_e6", 8'(Btn_pulse), 8'h00);
    check("press_level_e6", 8'(Btn_level), 8'h01);
    tick(13);

    // 3: bounce on channel 1 never accepted
    set_btn(3'b100);
    tick(2);
    set_btn(3'b110);
    set_btn(3'b100);
    tick(1);
    set_btn(3'b110);
    tick(8);
    check("bounce_level", 8'(Btn_level), 8'h01);
    check("bounce_pulse", 8'(Btn_pulse), 8'h00);

    // 4: release channel 0
    set_btn(3'b111);
    tick(5);
    check("release_level_e4", 8'(Btn_level), 8'h01);
    tick(1);
    check("release_level_e5", 8'(Btn_level), 8'h00);
    check("release_pulse_e5", 8'(Btn_pulse), 8'h00);
    tick(5);

    // 5: simultaneous press on all channels
    set_btn(3'b000);
    tick(5);
    check("simul_level_e4", 8'(Btn_level), 8'h00);
    tick(1);
    check("simul_level_e5", 8'(Btn_level), 8'h07);
    check("simul_pulse_e5", 8'(Btn_pulse), 8'h07);
    tick(1);
    check("simul_pulse_e6", 8'(Btn_pulse), 8'h00);
    tick(3);
    set_btn(3'b111);
    tick(10);

    // 6: reset in the middle of a debounce on channel 2
    set_btn(3'b011);
    tick(2);
    assert_reset();
    tick(2);
    check("midrst_level", 8'(Btn_level), 8'h00);
    check("midrst_pulse", 8'(Btn_pulse), 8'h00);
    release_reset();
    tick(5);
    check("midrst_level_e4", 8'(Btn_level), 8'h00);
    tick(1);
    check("midrst_level_e5", 8'(Btn_level), 8'h04);
    check("midrst_pulse_e5", 8'(Btn_pulse), 8'h04);
    check("midrst_sync_h", 8'(Reset_sync_h), 8'h00);
    set_btn(3'b111);
    tick(10);

    // Random bouncing buttons with occasional resets
    for (int i = 0; i < NUM_BTN; i++) hold[i] = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 399) == 0) begin
        assert_reset();
        tick($urandom_range(1, 3));
        release_reset();
      end else begin
        @(negedge Clk);
        for (int i = 0; i < NUM_BTN; i++) begin
          hold[i]--;
          if (hold[i] <= 0) begin
            Btn_n[i] = ~Btn_n[i];
            hold[i] = ($urandom_range(0, 2) == 0) ? $urandom_range(5, 15)
                                                  : $urandom_range(1, 3);
          end
        end
      end
    end
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/key_conditioner.md
Name: key_conditioner

Overview:
- Input-conditioning stage placed directly upstream of the multiplier control FSM.
- Takes raw active-low DE2 pushbuttons (Execute, LoadA/ClearA_LoadB, etc.) and the board reset key.
- Produces synchronized, debounced, active-high level signals. The control FSM needs these because it waits for Execute to fall before returning to its idle state.
- Also produces single-cycle press pulses, and a synchronous active-high reset for downstream logic.

Parameters:
- NUM_BTN, 3, number of button channels conditioned.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a change (10 ms at 50 MHz); minimum legal value 2.
- CNT_W, 19, counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- Clk  input  1  system clock, all state on rising edge.
- Reset  input  1  asynchronous, active-low reset (board KEY0).
- Btn_n  input  NUM_BTN  raw active-low pushbuttons, asynchronous to Clk, bouncing.
- Btn_level  output  NUM_BTN  debounced pressed level, active-high.
- Btn_pulse  output  NUM_BTN  one-cycle pulse on each accepted press.
- Reset_sync_h  output  1  active-high reset for downstream FSM/datapath; asynchronously asserted, synchronously released.

Behaviour:
- Reset low, asynchronously, per channel:
  - sync flops s1 and s2 <= 1 (released);
  - stable <= 0;
  - cnt <= 0;
  - Btn_level = 0;
  - Btn_pulse = 0;
  - reset synchronizer flops r1 and r2 <= 1, so Reset_sync_h = 1 immediately.
- Reset release:
  - r1 <= 0, then r2 <= r1.
  - Reset_sync_h falls on the 2nd rising Clk edge after Reset goes high.
  - Reset reasserted mid-operation: all state clears asynchronously, with no partial pulse.
- Synchronizer (per channel): s1 <= Btn_n[i], s2 <= s1. Define pressed_raw = ~s2.
- Per-channel debounce, evaluated each edge:
  - pressed_raw == stable: cnt <= 0.
  - pressed_raw != stable and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - pressed_raw != stable and cnt == DEBOUNCE_CYCLES-1: stable <= pressed_raw, cnt <= 0.
  - Any bounce back to the stable value before the terminal count restarts the count from 0.
- Per-channel FSM states (encoded by stable and whether cnt is nonzero):
  - RELEASED -> PRESS_PEND on pressed_raw = 1.
  - PRESS_PEND -> PRESSED at terminal count; back to RELEASED on bounce.
  - PRESSED -> REL_PEND on pressed_raw = 0.
  - REL_PEND -> RELEASED at terminal count; back to PRESSED on bounce.
- Latency:
  - Btn_n falls before edge 0; s2 shows the change after edge 1; cnt increments on edges 2..DEBOUNCE_CYCLES.
  - Btn_level rises after edge DEBOUNCE_CYCLES+1.
  - Release latency is identical.
- Btn_level = stable (registered).
- Btn_pulse[i]:
  - Registered; high for exactly the one cycle in which Btn_level[i] first reads 1 after a RELEASED->PRESSED transition.
  - No pulse on release.
  - Holding the button produces only one pulse.
- Channels are fully independent. Simultaneous presses on several channels produce simultaneous pulses.
- cnt never exceeds DEBOUNCE_CYCLES-1; there is no wrap-around.
- Btn_level and Btn_pulse are not gated by Reset_sync_h. They are already 0 after reset.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3, NUM_BTN=3):
1. Reset low for 3 cycles, then high:
   - Reset_sync_h = 1 during reset and on the 1st edge after release; 0 after the 2nd edge.
   - Btn_level = 000, Btn_pulse = 000 throughout.
2. Clean press: Btn_n[0] 1->0 before edge 0, held 20 cycles.
   - Btn_level[0] = 1 after edge 5.
   - Btn_pulse[0] = 1 for the single cycle after edge 5, 0 afterwards.
   - Channels 1 and 2 stay 0.
3. Bounce: Btn_n[1] low 3 cycles, high 1 cycle, low 2 cycles, high again.
   - No change on Btn_level[1] and no pulse; cnt returns to 0.
4. Release: after scenario 2, Btn_n[0] 0->1 before edge k.
   - Btn_level[0] = 0 after edge k+5; no pulse asserted.
5. Simultaneous: Btn_n = 3'b000 from 3'b111 on the same cycle.
   - All three levels rise after the same edge, with three concurrent one-cycle pulses.
6. Reset mid-debounce: channel 2 pressed 3 cycles, then Reset pulsed low.
   - Outputs stay 0; after release the channel needs a full fresh DEBOUNCE_CYCLES+2 edges to assert Btn_level[2].
